// File: rtl/phy_tx_lane_ser.sv
// Mainband TX lane serialiser: PLL-gated start-up FSM, LSB-first per-lane serialisation
// with lane reversal/masking shadows, valid framing, clock enable and track lane.
module phy_tx_lane_ser #(
    parameter int unsigned LANES      = 16,
    parameter int unsigned SER_RATIO  = 8,
    parameter int unsigned SETTLE_CYC = 64
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic                         i_pll_locked,
    input  logic                         i_enable,
    input  logic                         i_lane_reverse,
    input  logic [LANES-1:0]             i_lane_mask,
    input  logic                         i_in_valid,
    output logic                         o_in_ready,
    input  logic [LANES*SER_RATIO-1:0]   i_in_data,
    output logic [LANES-1:0]             o_tx_data,
    output logic                         o_tx_valid,
    output logic                         o_tx_clk_en,
    output logic                         o_tx_trk,
    output logic [1:0]                   o_state,
    output logic                         o_underflow,
    output logic                         o_lock_lost
);

    localparam int unsigned CW = $clog2(SER_RATIO);
    localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
    localparam int unsigned IW = $clog2(LANES * SER_RATIO);
    localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CW-1:0] LastBit = CW'(SER_RATIO - 1);
    localparam logic [CW-1:0] HalfBit = CW'(SER_RATIO / 2);

    typedef enum logic [1:0] {
        StOff    = 2'd0,
        StSettle = 2'd1,
        StIdle   = 2'd2,
        StActive = 2'd3
    } state_e;

    state_e                       r_state;
    logic [SW-1:0]                r_settle_cnt;
    logic [CW-1:0]                r_bit_cnt;
    logic [LANES*SER_RATIO-1:0]   r_word;
    logic                         r_rev;
    logic [LANES-1:0]             r_mask;
    logic [LANES-1:0]             r_tx_data;
    logic                         r_tx_valid;
    logic                         r_tx_clk_en;
    logic                         r_tx_trk;

    logic                         w_last;
    logic                         w_transfer;
    logic                         w_load;
    logic [CW-1:0]                w_bit_nxt;
    logic [LANES-1:0]             w_load_bits;
    logic [LANES-1:0]             w_next_bits;

    // Physical lane p carries logical lane (rev ? LANES-1-p : p), bit k of its field.
    function automatic logic [LANES-1:0] f_lane_bits(
        input logic [LANES*SER_RATIO-1:0] word,
        input logic [CW-1:0]              k,
        input logic                       rev,
        input logic [LANES-1:0]           mask
    );
        logic [LANES-1:0] bits;
        int unsigned      l;
        bits = '0;
        for (int unsigned p = 0; p < LANES; p++) begin
            l = rev ? (LANES - 1 - p) : p;
            bits[LW'(p)] = mask[LW'(p)] ? 1'b0 : word[IW'(l * SER_RATIO + k)];
        end
        return bits;
    endfunction

    assign w_last      = (r_bit_cnt == LastBit);
    assign w_bit_nxt   = r_bit_cnt + 1'b1;
    assign w_transfer  = i_in_valid & o_in_ready;
    assign w_load      = w_transfer & i_pll_locked;
    assign w_load_bits = f_lane_bits(i_in_data, '0, i_lane_reverse, i_lane_mask);
    assign w_next_bits = f_lane_bits(r_word, w_bit_nxt, r_rev, r_mask);

    always_comb begin
        o_in_ready = 1'b0;
        if (r_state == StIdle) begin
            o_in_ready = i_enable;
        end else if (r_state == StActive && w_last) begin
            o_in_ready = i_enable;
        end
    end

    assign o_underflow = (r_state == StActive) && w_last && i_enable && !i_in_valid
                         && i_pll_locked;
    assign o_lock_lost = (r_state != StOff) && !i_pll_locked;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= StOff;
            r_settle_cnt <= '0;
            r_bit_cnt    <= '0;
            r_tx_data    <= '0;
            r_tx_valid   <= 1'b0;
            r_tx_clk_en  <= 1'b0;
            r_tx_trk     <= 1'b0;
        end else begin
            // Serial outputs default to quiet; branches that keep the lane running override.
            r_tx_data   <= '0;
            r_tx_valid  <= 1'b0;
            r_tx_clk_en <= 1'b0;
            r_tx_trk    <= 1'b0;
            if (r_state != StOff && !i_pll_locked) begin
                r_state   <= StOff;
                r_bit_cnt <= '0;
            end else begin
                case (r_state)
                    StOff: begin
                        if (i_pll_locked && i_enable) begin
                            r_state      <= StSettle;
                            r_settle_cnt <= SW'(SETTLE_CYC - 1);
                        end
                    end
                    StSettle: begin
                        if (!i_enable) begin
                            r_state <= StOff;
                        end else if (r_settle_cnt == '0) begin
                            r_state  <= StIdle;
                            r_tx_trk <= 1'b1;
                        end else begin
                            r_settle_cnt <= r_settle_cnt - 1'b1;
                        end
                    end
                    StIdle: begin
                        if (!i_enable) begin
                            r_state <= StOff;
                        end else begin
                            r_tx_trk <= ~r_tx_trk;
                            if (i_in_valid) begin
                                r_state     <= StActive;
                                r_bit_cnt   <= '0;
                                r_tx_data   <= w_load_bits;
                                r_tx_valid  <= 1'b1;
                                r_tx_clk_en <= 1'b1;
                            end
                        end
                    end
                    StActive: begin
                        if (!w_last) begin
                            r_bit_cnt   <= w_bit_nxt;
                            r_tx_data   <= w_next_bits;
                            r_tx_valid  <= (w_bit_nxt < HalfBit);
                            r_tx_clk_en <= 1'b1;
                            r_tx_trk    <= ~r_tx_trk;
                        end else if (w_transfer) begin
                            r_bit_cnt   <= '0;
                            r_tx_data   <= w_load_bits;
                            r_tx_valid  <= 1'b1;
                            r_tx_clk_en <= 1'b1;
                            r_tx_trk    <= ~r_tx_trk;
                        end else if (i_enable) begin
                            r_state   <= StIdle;
                            r_bit_cnt <= '0;
                            r_tx_trk  <= 1'b1;
                        end else begin
                            r_state   <= StOff;
                            r_bit_cnt <= '0;
                        end
                    end
                    default: r_state <= StOff;
                endcase
            end
        end
    end

    // Lane config is captured with the word so mid-word changes wait for the next load.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_word <= '0;
            r_rev  <= 1'b0;
            r_mask <= '0;
        end else if (w_load) begin
            r_word <= i_in_data;
            r_rev  <= i_lane_reverse;
            r_mask <= i_lane_mask;
        end
    end

    assign o_tx_data   = r_tx_data;
    assign o_tx_valid  = r_tx_valid;
    assign o_tx_clk_en = r_tx_clk_en;
    assign o_tx_trk    = r_tx_trk;
    assign o_state     = r_state;

endmodule

// File: tb/tb_phy_tx_lane_ser.sv
// Bench for phy_tx_lane_ser: word-level behavioural model checked every cycle, directed
// start-up/framing/reversal/underflow/enable/lock scenarios, then randomized traffic.
module tb_phy_tx_lane_ser;

    localparam int LANES  = 4;
    localparam int SER    = 8;
    localparam int SETTLE = 64;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b1;
    logic                   pll_locked = 1'b0;
    logic                   enable = 1'b0;
    logic                   lane_reverse = 1'b0;
    logic [LANES-1:0]       lane_mask = '0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [LANES*SER-1:0]   in_data = '0;
    logic [LANES-1:0]       tx_data;
    logic                   tx_valid;
    logic                   tx_clk_en;
    logic                   tx_trk;
    logic [1:0]             state;
    logic                   underflow;
    logic                   lock_lost;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    phy_tx_lane_ser #(
        .LANES      (LANES),
        .SER_RATIO  (SER),
        .SETTLE_CYC (SETTLE)
    ) u_dut (
        .i_clk          (clk),
        .i_reset_n      (reset_n),
        .i_pll_locked   (pll_locked),
        .i_enable       (enable),
        .i_lane_reverse (lane_reverse),
        .i_lane_mask    (lane_mask),
        .i_in_valid     (in_valid),
        .o_in_ready     (in_ready),
        .i_in_data      (in_data),
        .o_tx_data      (tx_data),
        .o_tx_valid     (tx_valid),
        .o_tx_clk_en    (tx_clk_en),
        .o_tx_trk       (tx_trk),
        .o_state        (state),
        .o_underflow    (underflow),
        .o_lock_lost    (lock_lost)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: mode 0 OFF, 1 SETTLE, 2 IDLE, 3 ACTIVE; pos is the UI index inside the word.
    int m_mode = 0;
    int m_left = 0;
    int m_pos = 0;
    int m_word[LANES];
    bit m_rev = 1'b0;
    int m_mask = 0;
    bit m_trk = 1'b0;

    task automatic m_load();
        for (int l = 0; l < LANES; l++) begin
            m_word[l] = int'((in_data >> (l * SER)) & ((1 << SER) - 1));
        end
        m_rev  = lane_reverse;
        m_mask = int'(lane_mask);
        m_pos  = 0;
        m_mode = 3;
    endtask

    initial begin
        for (int l = 0; l < LANES; l++) m_word[l] = 0;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_mode = 0;
                m_pos  = 0;
                m_trk  = 1'b0;
            end else if (m_mode != 0 && !pll_locked) begin
                m_mode = 0;
                m_trk  = 1'b0;
            end else begin
                case (m_mode)
                    0: if (pll_locked && enable) begin
                        m_mode = 1;
                        m_left = SETTLE;
                    end
                    1: if (!enable) m_mode = 0;
                       else begin
                           m_left--;
                           if (m_left == 0) begin
                               m_mode = 2;
                               m_trk  = 1'b1;
                           end
                       end
                    2: if (!enable) begin
                           m_mode = 0;
                           m_trk  = 1'b0;
                       end else begin
                           m_trk = ~m_trk;
                           if (in_valid) m_load();
                       end
                    default: if (m_pos < SER - 1) begin
                           m_pos++;
                           m_trk = ~m_trk;
                       end else if (enable && in_valid) begin
                           m_load();
                           m_trk = ~m_trk;
                       end else if (enable) begin
                           m_mode = 2;
                           m_trk  = 1'b1;
                       end else begin
                           m_mode = 0;
                           m_trk  = 1'b0;
                       end
                endcase
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (chk_on) begin
                int e_data;
                bit act;
                bit last;
                act  = (m_mode == 3);
                last = act && (m_pos == SER - 1);
                e_data = 0;
                if (act) begin
                    for (int p = 0; p < LANES; p++) begin
                        int l;
                        l = m_rev ? (LANES - 1 - p) : p;
                        if (((m_mask >> p) & 1) == 0) e_data |= ((m_word[l] >> m_pos) & 1) << p;
                    end
                end
                chk("m_state", int'(state), m_mode);
                chk("m_tx_data", int'(tx_data), e_data);
                chk("m_tx_valid", int'(tx_valid), int'(act && m_pos < SER / 2));
                chk("m_tx_clk_en", int'(tx_clk_en), int'(act));
                chk("m_tx_trk", int'(tx_trk), int'(m_trk));
                chk("m_in_ready", int'(in_ready), int'(enable && (m_mode == 2 || last)));
                chk("m_underflow", int'(underflow),
                    int'(last && enable && !in_valid && pll_locked));
                chk("m_lock_lost", int'(lock_lost), int'(m_mode != 0 && !pll_locked));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic peek();
        #3;
    endtask

    task automatic measure_settle(input string name);
        int n;
        n = 0;
        while (state == 2'd1 && n < 200) begin
            n++;
            tick();
            peek();
        end
        chk({name, "_len"}, n, SETTLE);
        chk({name, "_idle"}, int'(state), 2);
        chk({name, "_trk_start"}, int'(tx_trk), 1);
    endtask

    task automatic wait_state(input int s, input int budget, input string name);
        int n;
        n = 0;
        while (int'(state) != s && n < budget) begin
            n++;
            tick();
            peek();
        end
        chk(name, int'(state), s);
    endtask

    logic [SER-1:0] cap0, capv, capr;
    int n_act;
    bit uf_seen;

    initial begin
        #1 reset_n = 1'b0;
        chk_on = 1'b1;
        repeat (3) tick();
        peek();
        chk("rst_state", int'(state), 0);
        chk("rst_tx_data", int'(tx_data), 0);
        chk("rst_trk", int'(tx_trk), 0);
        chk("rst_ready", int'(in_ready), 0);

        // Start-up: release with lock and enable, 64 cycles of SETTLE, then IDLE
        tick();
        reset_n = 1'b1; pll_locked = 1'b1; enable = 1'b1;
        tick();
        peek();
        chk("settle_entry", int'(state), 1);
        measure_settle("settle1");
        tick();
        peek();
        chk("trk_toggle", int'(tx_trk), 0);

        // Two back-to-back words on lane 0, then underflow
        tick();
        in_valid = 1'b1;
        in_data  = 32'h0000_00A5;
        peek();
        chk("idle_ready", int'(in_ready), 1);
        for (int k = 0; k < SER; k++) begin
            tick();
            if (k == 0) in_data = 32'h0000_003C;
            peek();
            cap0[k] = tx_data[0];
            capv[k] = tx_valid;
            capr[k] = in_ready;
        end
        chk("word1_lane0", int'(cap0), 'hA5);
        chk("word1_valid", int'(capv), 'h0F);
        chk("word1_ready", int'(capr), 'h80);
        for (int k = 0; k < SER; k++) begin
            tick();
            if (k == 0) in_valid = 1'b0;
            peek();
            cap0[k] = tx_data[0];
            if (k == SER - 1) chk("underflow_pulse", int'(underflow), 1);
        end
        chk("word2_lane0", int'(cap0), 'h3C);

        // Reversal and mask, with config changes mid-word
        tick();
        in_valid = 1'b1;
        in_data = 32'h00FF_00FF;
        lane_reverse = 1'b1;
        lane_mask = 4'b0010;
        peek();
        chk("uf_idle", int'(state), 2);
        chk("uf_valid", int'(tx_valid), 0);
        chk("uf_clk_en", int'(tx_clk_en), 0);
        for (int k = 0; k < SER; k++) begin
            tick();
            if (k == 0) begin
                in_valid = 1'b0;
                lane_mask = 4'b0000;
                lane_reverse = 1'b0;
            end
            peek();
            if (k == 0) chk("rev_active", int'(state), 3);
            chk("rev_mask_data", int'(tx_data), 'b1000);
        end

        // Enable dropped at bit 3: word completes, no underflow, then OFF
        tick();
        in_valid = 1'b1;
        in_data = 32'h5A5A_5A5A;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 0) in_valid = 1'b0;
        end
        enable = 1'b0;
        n_act = 0;
        uf_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            peek();
            uf_seen |= underflow;
            if (state != 2'd3) break;
            n_act++;
        end
        chk("en_drop_bits", n_act, 4);
        chk("en_drop_off", int'(state), 0);
        chk("en_drop_no_uf", int'(uf_seen), 0);
        enable = 1'b1;
        wait_state(2, 100, "resettle_idle");

        // Lock lost at bit 2
        tick();
        in_valid = 1'b1;
        in_data = 32'hFFFF_FFFF;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        pll_locked = 1'b0;
        peek();
        chk("lock_lost_pulse", int'(lock_lost), 1);
        tick();
        peek();
        chk("lock_off", int'(state), 0);
        chk("lock_tx_data", int'(tx_data), 0);
        chk("lock_trk", int'(tx_trk), 0);
        pll_locked = 1'b1;
        tick();
        peek();
        chk("relock_settle", int'(state), 1);
        measure_settle("settle2");

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            tick();
            pll_locked   = ($urandom_range(0, 255) != 0);
            enable       = ($urandom_range(0, 63) != 0);
            in_valid     = ($urandom_range(0, 3) != 0);
            in_data      = $urandom;
            lane_reverse = $urandom_range(0, 1) == 1;
            lane_mask    = 4'($urandom_range(0, 15));
        end
        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
